// File: rtl/simple_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : simple_adder_pkg
//  Description : Shared word geometry and FSM encoding for the
//                deserializer and the downstream adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package simple_adder_pkg;

   localparam int WORD_W = 25;             // width of one signed data word
   localparam int NWORDS = 4;              // words per full frame
   localparam int IDX_W  = 2;              // collection index width
   localparam int CNT_W  = IDX_W + 1;      // frame word count (1..NWORDS)

   // COLLECT: gathering words, nothing pending.
   // HOLD   : a completed frame waits in the collection bank for the output slot.
   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } state_e;

endpackage : simple_adder_pkg
`default_nettype wire

// File: rtl/word_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : word_deserializer_if
//  Description : Serial word input stream plus parallel frame output of the
//                word deserializer.
//  Signals     : IN_WORD/IN_VALID/IN_LAST/IN_READY - serial word handshake
//                WORD_0..WORD_3/OUT_COUNT/OUT_VALID/OUT_READY - frame handshake
//  Modports    : slave  - the deserializer itself
//                master - the environment (word source and frame consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface word_deserializer_if
   import simple_adder_pkg::*;
#(
   parameter int WIDTH = WORD_W
) ();

   logic [WIDTH-1:0] IN_WORD;
   logic             IN_VALID;
   logic             IN_LAST;
   logic             IN_READY;

   logic [WIDTH-1:0] WORD_0;
   logic [WIDTH-1:0] WORD_1;
   logic [WIDTH-1:0] WORD_2;
   logic [WIDTH-1:0] WORD_3;
   logic [CNT_W-1:0] OUT_COUNT;
   logic             OUT_VALID;
   logic             OUT_READY;

   modport slave (
      input  IN_WORD, IN_VALID, IN_LAST, OUT_READY,
      output IN_READY, WORD_0, WORD_1, WORD_2, WORD_3, OUT_COUNT, OUT_VALID
   );

   modport master (
      output IN_WORD, IN_VALID, IN_LAST, OUT_READY,
      input  IN_READY, WORD_0, WORD_1, WORD_2, WORD_3, OUT_COUNT, OUT_VALID
   );

endinterface : word_deserializer_if
`default_nettype wire

// File: rtl/word_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : word_deserializer
//  Description : Collects up to four signed serial words into a parallel
//                frame. A frame closes on its fourth word or on IN_LAST.
//                Completed frames move to a one-deep output bank; if that
//                bank is still occupied the frame waits in the collection
//                bank (HOLD) and input is stalled until the bank frees.
//  Ports       : CLK   - rising-edge clock
//                RST_N - asynchronous active-low reset
//                bus   - word_deserializer_if.slave (input stream + frame out)
//  Revision    : 1.0 - initial release
// ============================================================================
module word_deserializer
   import simple_adder_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  wire logic          CLK,
   input  wire logic          RST_N,
   word_deserializer_if.slave bus
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e             state_q,     state_d;
   logic [IDX_W-1:0]   idx_q,       idx_d;
   logic [CNT_W-1:0]   hold_cnt_q,  hold_cnt_d;
   logic [WIDTH-1:0]   coll_q [NWORDS];
   logic [WIDTH-1:0]   coll_d [NWORDS];
   logic [WIDTH-1:0]   out_q  [NWORDS];
   logic [WIDTH-1:0]   out_d  [NWORDS];
   logic [CNT_W-1:0]   out_cnt_q,   out_cnt_d;
   logic               out_valid_q, out_valid_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic               slot_free;
   logic               in_ready;
   logic               accept;
   logic               completes;
   logic [CNT_W-1:0]   cur_cnt;
   logic [WIDTH-1:0]   frame [NWORDS];

   always_comb begin
      slot_free = !out_valid_q || bus.OUT_READY;
      // In HOLD, input may flow only on the edge that also drains the held frame.
      in_ready  = (state_q == ST_COLLECT) || slot_free;
      accept    = bus.IN_VALID && in_ready;
      completes = accept && ((idx_q == IDX_W'(NWORDS - 1)) || bus.IN_LAST);
      cur_cnt   = {1'b0, idx_q} + CNT_W'(1);

      // Collection bank as it would look with the current word written.
      // Slots above the current index are forced to zero, so a short frame
      // never carries words left over from an earlier frame.
      for (int i = 0; i < NWORDS; i++) begin
         if (i == int'(idx_q)) begin
            frame[i] = bus.IN_WORD;
         end else if (i > int'(idx_q)) begin
            frame[i] = '0;
         end else begin
            frame[i] = coll_q[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      hold_cnt_d  = hold_cnt_q;
      coll_d      = coll_q;
      out_d       = out_q;
      out_cnt_d   = out_cnt_q;
      // A consumed frame retires; a load below re-asserts valid.
      out_valid_d = out_valid_q && !bus.OUT_READY;

      // Drain a held frame as soon as the output slot frees.
      if ((state_q == ST_HOLD) && slot_free) begin
         out_d       = coll_q;
         out_cnt_d   = hold_cnt_q;
         out_valid_d = 1'b1;
         state_d     = ST_COLLECT;
      end

      if (accept) begin
         coll_d = frame;
         idx_d  = idx_q + IDX_W'(1);

         if (completes) begin
            idx_d = '0;
            // Only a COLLECT-state completion can use a free slot directly;
            // in HOLD the slot is being refilled by the held frame this edge.
            if ((state_q == ST_COLLECT) && slot_free) begin
               out_d       = frame;
               out_cnt_d   = cur_cnt;
               out_valid_d = 1'b1;
            end else begin
               state_d    = ST_HOLD;
               hold_cnt_d = cur_cnt;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_COLLECT;
         idx_q       <= '0;
         hold_cnt_q  <= '0;
         out_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < NWORDS; i++) begin
            coll_q[i] <= '0;
            out_q[i]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         hold_cnt_q  <= hold_cnt_d;
         out_cnt_q   <= out_cnt_d;
         out_valid_q <= out_valid_d;
         for (int i = 0; i < NWORDS; i++) begin
            coll_q[i] <= coll_d[i];
            out_q[i]  <= out_d[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.IN_READY  = in_ready;
   assign bus.WORD_0    = out_q[0];
   assign bus.WORD_1    = out_q[1];
   assign bus.WORD_2    = out_q[2];
   assign bus.WORD_3    = out_q[3];
   assign bus.OUT_COUNT = out_cnt_q;
   assign bus.OUT_VALID = out_valid_q;

endmodule : word_deserializer
`default_nettype wire
